// File: rtl/top_module_hls_deadlock_report_ctrl_if.sv
// Bundle of the deadlock report controller's functional signals.
// master: supervisor side (drives enable/mon_block/ack, observes the report).
// slave : the report controller itself.
//   enable, mon_block, ack                      -> controller
//   irq, dl_valid, dl_idx, dl_vec, dl_cycle,
//   event_count                                 <- controller
interface top_module_hls_deadlock_report_ctrl_if #(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned CNT_W   = 32
);
    localparam int unsigned IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

    logic                enable;
    logic [NUM_MON-1:0]  mon_block;
    logic                ack;
    logic                irq;
    logic                dl_valid;
    logic [IDX_W-1:0]    dl_idx;
    logic [NUM_MON-1:0]  dl_vec;
    logic [CNT_W-1:0]    dl_cycle;
    logic [15:0]         event_count;

    modport master (
        output enable, mon_block, ack,
        input  irq, dl_valid, dl_idx, dl_vec, dl_cycle, event_count
    );

    modport slave (
        input  enable, mon_block, ack,
        output irq, dl_valid, dl_idx, dl_vec, dl_cycle, event_count
    );
endinterface

// File: rtl/top_module_hls_deadlock_report_ctrl.sv
// Supervisory controller for the per-dataflow HLS deadlock monitors.
// Debounces the monitor block flags, picks the lowest-index candidate, latches
// one timestamped report and holds a level IRQ until software acks. Re-arms
// only once every monitor has cleared.
// Ports:
//   clock    design clock
//   reset_n  async active-low reset
//   bus      slave side of the report interface (enable, mon_block, ack in;
//            irq, dl_valid, dl_idx, dl_vec, dl_cycle, event_count out)
module top_module_hls_deadlock_report_ctrl #(
    parameter int unsigned NUM_MON  = 4,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic clock,
    input  logic reset_n,
    top_module_hls_deadlock_report_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
    localparam int unsigned DBC_W = $clog2(DEBOUNCE + 1);

    // Elaboration-time parameter sanity
    generate
        if (DEBOUNCE == 0 || NUM_MON == 0) begin : g_param_check
            $error("top_module_hls_deadlock_report_ctrl: DEBOUNCE and NUM_MON must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DEBOUNCE,
        ST_REPORT,
        ST_HOLDOFF
    } state_t;

    state_t              state_q,  state_nxt;
    logic [IDX_W-1:0]    cand_q,   cand_nxt;
    logic [DBC_W-1:0]    dbc_q,    dbc_nxt;
    logic [CNT_W-1:0]    cyc_q,    cyc_nxt;
    logic                irq_q,    irq_nxt;
    logic                valid_q,  valid_nxt;
    logic [IDX_W-1:0]    idx_q,    idx_nxt;
    logic [NUM_MON-1:0]  vec_q,    vec_nxt;
    logic [CNT_W-1:0]    cycle_q,  cycle_nxt;
    logic [15:0]         evc_q,    evc_nxt;
    logic                capture_c;
    logic [IDX_W-1:0]    cap_idx_c;
    logic [IDX_W-1:0]    lowest_c;

    // Fixed priority: lowest set index wins
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign lowest_c = lowest_set(bus.mon_block);

    // Next-state, counters and report capture
    always_comb begin
        state_nxt = state_q;
        cand_nxt  = cand_q;
        dbc_nxt   = dbc_q;
        cyc_nxt   = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        valid_nxt = valid_q;
        idx_nxt   = idx_q;
        vec_nxt   = vec_q;
        cycle_nxt = cycle_q;
        evc_nxt   = evc_q;
        capture_c = 1'b0;
        cap_idx_c = cand_q;

        if (!bus.enable) begin
            // Disable dominates ack and any capture on the same edge
            state_nxt = ST_IDLE;
            cand_nxt  = '0;
            dbc_nxt   = '0;
            cyc_nxt   = '0;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
            vec_nxt   = '0;
            cycle_nxt = '0;
            evc_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cyc_nxt   = '0;
                    state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (|bus.mon_block) begin
                        cand_nxt = lowest_c;
                        if (DEBOUNCE == 1) begin
                            capture_c = 1'b1;
                            cap_idx_c = lowest_c;
                            state_nxt = ST_REPORT;
                        end else begin
                            dbc_nxt   = DBC_W'(1);
                            state_nxt = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    // Candidate is locked; a new higher-priority bit does not preempt
                    if (!bus.mon_block[cand_q]) begin
                        dbc_nxt   = '0;
                        state_nxt = ST_ARMED;
                    end else if (dbc_q == DBC_W'(DEBOUNCE - 1)) begin
                        dbc_nxt   = '0;
                        capture_c = 1'b1;
                        state_nxt = ST_REPORT;
                    end else begin
                        dbc_nxt = dbc_q + DBC_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (bus.ack) state_nxt = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (bus.mon_block == '0) state_nxt = ST_ARMED;
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (capture_c) begin
                valid_nxt = 1'b1;
                idx_nxt   = cap_idx_c;
                vec_nxt   = bus.mon_block;
                cycle_nxt = cyc_q;
                evc_nxt   = (evc_q == 16'hFFFF) ? evc_q : evc_q + 16'd1;
            end
        end

        irq_nxt = (state_nxt == ST_REPORT);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            dbc_q   <= '0;
            cyc_q   <= '0;
            irq_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            vec_q   <= '0;
            cycle_q <= '0;
            evc_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cand_q  <= cand_nxt;
            dbc_q   <= dbc_nxt;
            cyc_q   <= cyc_nxt;
            irq_q   <= irq_nxt;
            valid_q <= valid_nxt;
            idx_q   <= idx_nxt;
            vec_q   <= vec_nxt;
            cycle_q <= cycle_nxt;
            evc_q   <= evc_nxt;
        end
    end

    assign bus.irq         = irq_q;
    assign bus.dl_valid    = valid_q;
    assign bus.dl_idx      = idx_q;
    assign bus.dl_vec      = vec_q;
    assign bus.dl_cycle    = cycle_q;
    assign bus.event_count = evc_q;
endmodule

// File: tb/tb_top_module_hls_deadlock_report_ctrl.sv
// Bench for the deadlock report controller: two instances (DEBOUNCE=4/CNT_W=32
// and DEBOUNCE=1/CNT_W=4). Stimulus pushes expected reports; monitors pop and
// compare on every rising irq.
module tb_top_module_hls_deadlock_report_ctrl;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    int edge_no = 0;
    always @(posedge clock) edge_no++;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0] idx;
        logic [63:0] vec;
        logic [63:0] cyc;
        logic [63:0] ev;
        int          edge_n;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    top_module_hls_deadlock_report_ctrl_if #(.NUM_MON(4), .CNT_W(32)) bus1 ();
    top_module_hls_deadlock_report_ctrl_if #(.NUM_MON(4), .CNT_W(4))  bus2 ();

    top_module_hls_deadlock_report_ctrl #(.NUM_MON(4), .DEBOUNCE(4), .CNT_W(32)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    top_module_hls_deadlock_report_ctrl #(.NUM_MON(4), .DEBOUNCE(1), .CNT_W(4)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push1(input int idx, input logic [3:0] vec, input longint cyc,
                         input int ev, input int e);
        exp_t x;
        x.idx = 64'(idx); x.vec = 64'(vec); x.cyc = 64'(cyc); x.ev = 64'(ev); x.edge_n = e;
        q1.push_back(x);
    endtask

    task automatic push2(input int idx, input logic [3:0] vec, input longint cyc,
                         input int ev, input int e);
        exp_t x;
        x.idx = 64'(idx); x.vec = 64'(vec); x.cyc = 64'(cyc); x.ev = 64'(ev); x.edge_n = e;
        q2.push_back(x);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_irq"},   64'(bus1.irq),         64'd0);
        chk({tag, "_valid"}, 64'(bus1.dl_valid),    64'd0);
        chk({tag, "_idx"},   64'(bus1.dl_idx),      64'd0);
        chk({tag, "_vec"},   64'(bus1.dl_vec),      64'd0);
        chk({tag, "_cycle"}, 64'(bus1.dl_cycle),    64'd0);
        chk({tag, "_evc"},   64'(bus1.event_count), 64'd0);
    endtask

    // Report monitors: a rising irq must match the oldest expected report
    logic irq1_d = 1'b0;
    logic irq2_d = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (bus1.irq === 1'b1 && irq1_d !== 1'b1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_irq", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("d1_edge",  64'(edge_no),          64'(e.edge_n));
                chk("d1_valid", 64'(bus1.dl_valid),    64'd1);
                chk("d1_idx",   64'(bus1.dl_idx),      e.idx);
                chk("d1_vec",   64'(bus1.dl_vec),      e.vec);
                chk("d1_cycle", 64'(bus1.dl_cycle),    e.cyc);
                chk("d1_evc",   64'(bus1.event_count), e.ev);
            end
        end
        irq1_d = bus1.irq;
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus2.irq === 1'b1 && irq2_d !== 1'b1) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_irq", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                chk("d2_edge",  64'(edge_no),          64'(e.edge_n));
                chk("d2_valid", 64'(bus2.dl_valid),    64'd1);
                chk("d2_idx",   64'(bus2.dl_idx),      e.idx);
                chk("d2_vec",   64'(bus2.dl_vec),      e.vec);
                chk("d2_cycle", 64'(bus2.dl_cycle),    e.cyc);
                chk("d2_evc",   64'(bus2.event_count), e.ev);
            end
        end
        irq2_d = bus2.irq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k1;
        int c;
        bus1.enable = 1'b0; bus1.mon_block = 4'b0000; bus1.ack = 1'b0;
        bus2.enable = 1'b0; bus2.mon_block = 4'b0000; bus2.ack = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        #2 chk_zero1("rst");
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // 1: single candidate, latency and timestamp (cyc_cnt at edge C is C-K-1)
        bus1.enable = 1'b1; k1 = edge_no + 1;
        tick(1);
        bus1.mon_block = 4'b0100; c = edge_no + 4;
        push1(2, 4'b0100, longint'(c - k1 - 1), 1, c);
        tick(5);
        chk("t1_irq_held", 64'(bus1.irq), 64'd1);
        bus1.ack = 1'b1; tick(1); bus1.ack = 1'b0; tick(1);
        chk("t1_irq_after_ack", 64'(bus1.irq),      64'd0);
        chk("t1_valid_hold",    64'(bus1.dl_valid), 64'd1);
        chk("t1_idx_hold",      64'(bus1.dl_idx),   64'd2);
        bus1.mon_block = 4'b0000; tick(1);

        // 2: short glitch is rejected, full-length assertion reports
        bus1.mon_block = 4'b0010; tick(3);
        bus1.mon_block = 4'b0000; tick(2);
        chk("t2_no_irq", 64'(bus1.irq),         64'd0);
        chk("t2_evc",    64'(bus1.event_count), 64'd1);
        bus1.mon_block = 4'b0010; c = edge_no + 4;
        push1(1, 4'b0010, longint'(c - k1 - 1), 2, c);
        tick(4);
        bus1.mon_block = 4'b0000; tick(2);
        chk("t2_irq_level", 64'(bus1.irq), 64'd1);
        bus1.ack = 1'b1; tick(1); bus1.ack = 1'b0; tick(1);

        // 3: simultaneous bits -> lowest index; late higher-priority bit does not preempt
        bus1.mon_block = 4'b1010; c = edge_no + 4;
        push1(1, 4'b1010, longint'(c - k1 - 1), 3, c);
        tick(4);
        bus1.ack = 1'b1; bus1.mon_block = 4'b0000; tick(1); bus1.ack = 1'b0; tick(1);
        bus1.mon_block = 4'b1000; c = edge_no + 4;
        push1(3, 4'b1001, longint'(c - k1 - 1), 4, c);
        tick(2);
        bus1.mon_block = 4'b1001; tick(3);

        // 4: ack while blocked -> HOLDOFF, no re-report until all clear
        bus1.mon_block = 4'b0001; tick(1);
        bus1.ack = 1'b1; tick(1); bus1.ack = 1'b0; tick(2);
        chk("t4_irq_cleared", 64'(bus1.irq),         64'd0);
        chk("t4_vec_hold",    64'(bus1.dl_vec),      64'h9);
        chk("t4_idx_hold",    64'(bus1.dl_idx),      64'd3);
        tick(4);
        chk("t4_holdoff_irq", 64'(bus1.irq),         64'd0);
        chk("t4_holdoff_evc", 64'(bus1.event_count), 64'd4);
        bus1.mon_block = 4'b0000; tick(1);
        bus1.mon_block = 4'b0001; c = edge_no + 4;
        push1(0, 4'b0001, longint'(c - k1 - 1), 5, c);
        tick(4);

        // 5a: disable together with ack in REPORT
        chk("t5_irq_before_dis", 64'(bus1.irq), 64'd1);
        bus1.ack = 1'b1; bus1.enable = 1'b0; tick(1);
        bus1.ack = 1'b0; bus1.mon_block = 4'b0000;
        chk_zero1("t5_dis_ack");

        // 5b: disable on the would-be capture edge
        bus1.enable = 1'b1; k1 = edge_no + 1; tick(1);
        bus1.mon_block = 4'b0001; tick(3);
        bus1.enable = 1'b0; tick(1);
        chk_zero1("t5_dis_cap");
        bus1.mon_block = 4'b0000; tick(2);

        // 5c: async reset in the middle of debounce
        bus1.enable = 1'b1; k1 = edge_no + 1; tick(1);
        bus1.mon_block = 4'b0001; c = edge_no + 4;
        push1(0, 4'b0001, longint'(c - k1 - 1), 1, c);
        tick(4);
        bus1.ack = 1'b1; bus1.mon_block = 4'b0000; tick(1); bus1.ack = 1'b0; tick(1);
        chk("t5_valid_pre_rst", 64'(bus1.dl_valid),    64'd1);
        chk("t5_evc_pre_rst",   64'(bus1.event_count), 64'd1);
        bus1.mon_block = 4'b0001; tick(2);
        #2 reset_n = 1'b0;
        #1 chk_zero1("t5_async_rst");
        bus1.enable = 1'b0; bus1.mon_block = 4'b0000;
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // 6: DEBOUNCE=1 captures on the first sampled-high edge; 4-bit timestamp saturates
        bus2.enable = 1'b1; tick(1);
        bus2.mon_block = 4'b0001; c = edge_no + 1;
        push2(0, 4'b0001, 0, 1, c);
        tick(2);
        chk("t6_irq", 64'(bus2.irq), 64'd1);
        bus2.ack = 1'b1; bus2.mon_block = 4'b0000; tick(1); bus2.ack = 1'b0;
        tick(20);
        bus2.mon_block = 4'b0010; c = edge_no + 1;
        push2(1, 4'b0010, 15, 2, c);
        tick(2);
        chk("t6_cycle_sat", 64'(bus2.dl_cycle), 64'hF);

        tick(2);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
